// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: two half-subtractor stages, borrows ORed.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic hs1_diff, hs1_bout, hs2_bout;

   // first stage subtracts b from a, second stage subtracts the incoming borrow
   always_comb begin
      hs1_diff = a ^ b;
      hs1_bout = ~a & b;
      diff     = hs1_diff ^ bin;
      hs2_bout = ~hs1_diff & bin;
      bout     = hs1_bout | hs2_bout;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borr
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   // one extra bit so the count can reach WIDTH without wrapping
   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q, out_valid_q;
   logic             step_d, step_bout_d;
   logic             last_step;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   full_sub u_step (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (borrow_q),
      .diff (step_d),
      .bout (step_bout_d)
   );

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   // control FSM plus the operand/result shift datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         borrow_q    <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  res_q      <= '0;
                  borrow_q   <= 1'b0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  ovf_q      <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               res_q    <= {step_d, res_q[WIDTH-1:1]};
               borrow_q <= step_bout_d;
               cnt_q    <= cnt_q + 1'b1;
               if (last_step) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  // a_q[0]/b_q[0] are the operand MSBs on the final step
                  ovf_q       <= (a_q[0] != b_q[0]) && (step_d != a_q[0]);
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = res_q;
   assign borr      = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       borr;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif
   logic       last_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borr      (borr)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operand pair (block must be IDLE, out_ready=1), returns the
   // result, and the number of edges from accept to out_valid (-1 on timeout).
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] d, output logic br, output int lat);
      lat = -1;
      d = 8'h00;
      br = 1'b0;
      a = av;
      b = bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      d  = diff;
      br = borr;
`ifdef SERIAL_SUB_OVF_EN
      last_ovf = ovf;
`else
      last_ovf = 1'b0;
`endif
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 8'h00;
      b = 8'h00;
      tick();
      tick();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borr !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h borr=%b, want 1 0 00 0",
                  in_ready, out_valid, diff, borr);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_tests++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %b want 0", ovf);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] d;
      logic br;
      int lat;
      run_op(8'h05, 8'h03, d, br, lat);
      n_tests++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL latency: got %0d want 8", lat);
      end
      n_tests++;
      if (d !== 8'h02 || br !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_05_03: diff=%h borr=%b want 02 0", d, br);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] d;
      logic br;
      int lat;
      run_op(8'h03, 8'h05, d, br, lat);
      n_tests++;
      if (d !== 8'hFE || br !== 1'b1 || lat !== 8) begin
         n_fail++;
         $display("FAIL sub_03_05: diff=%h borr=%b lat=%0d want FE 1 8", d, br, lat);
      end
      run_op(8'hFF, 8'hFF, d, br, lat);
      n_tests++;
      if (d !== 8'h00 || br !== 1'b0 || lat !== 8) begin
         n_fail++;
         $display("FAIL sub_FF_FF: diff=%h borr=%b lat=%0d want 00 0 8", d, br, lat);
      end
      run_op(8'h00, 8'hFF, d, br, lat);
      n_tests++;
      if (d !== 8'h01 || br !== 1'b1 || lat !== 8) begin
         n_fail++;
         $display("FAIL sub_00_FF: diff=%h borr=%b lat=%0d want 01 1 8", d, br, lat);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [7:0] d;
      logic br;
      out_ready = 1'b0;
      a = 8'h5A;
      b = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      n_tests++;
      if (lat !== 8 || diff !== 8'h1E || borr !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_result: lat=%0d diff=%h borr=%b want 8 1E 0", lat, diff, borr);
      end
      // offer new operands while the result is waiting; they must not be taken
      in_valid = 1'b1;
      a = 8'h77;
      b = 8'h11;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || diff !== 8'h1E || borr !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b diff=%h borr=%b in_ready=%b want 1 1E 0 0",
                     i, out_valid, diff, borr, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      run_op(8'h3C, 8'h5A, d, br, lat);
      n_tests++;
      if (d !== 8'hE2 || br !== 1'b1 || lat !== 8) begin
         n_fail++;
         $display("FAIL bp_next: diff=%h borr=%b lat=%0d want E2 1 8", d, br, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic br;
      int lat;
      int seen;
      a = 8'hC3;
      b = 8'h21;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borr !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_state: in_ready=%b out_valid=%b diff=%h borr=%b want 1 0 00 0",
                  in_ready, out_valid, diff, borr);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrst_no_valid: out_valid seen %0d cycles want 0", seen);
      end
      run_op(8'h10, 8'h01, d, br, lat);
      n_tests++;
      if (d !== 8'h0F || br !== 1'b0 || lat !== 8) begin
         n_fail++;
         $display("FAIL midrst_fresh: diff=%h borr=%b lat=%0d want 0F 0 8", d, br, lat);
      end
   endtask

   task automatic test_input_change();
      int lat;
      a = 8'h5A;
      b = 8'h3C;
      in_valid = 1'b1;
      tick();
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         in_valid = ~in_valid;
         a = a + 8'h37;
         b = b ^ 8'hA5;
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (lat !== 8 || diff !== 8'h1E || borr !== 1'b0) begin
         n_fail++;
         $display("FAIL input_change: lat=%0d diff=%h borr=%b want 8 1E 0", lat, diff, borr);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int first, second, cyc;
      int nres;
      logic [7:0] d1, d2;
      logic b1, b2;
      first = -1;
      second = -1;
      nres = 0;
      d1 = 8'h00; d2 = 8'h00; b1 = 1'b0; b2 = 1'b0;
      a = 8'h20;
      b = 8'h08;
      in_valid = 1'b1;
      cyc = 0;
      while (nres < 2 && cyc < 60) begin
         tick();
         cyc++;
         if (out_valid) begin
            if (nres == 0) begin
               first = cyc;
               d1 = diff;
               b1 = borr;
               a = 8'h08;
               b = 8'h20;
            end else begin
               second = cyc;
               d2 = diff;
               b2 = borr;
               in_valid = 1'b0;
            end
            nres++;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (d1 !== 8'h18 || b1 !== 1'b0 || d2 !== 8'hE8 || b2 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_results: %h/%b %h/%b want 18/0 E8/1", d1, b1, d2, b2);
      end
      n_tests++;
      if (nres !== 2 || (second - first) !== 10) begin
         n_fail++;
         $display("FAIL b2b_interval: results=%0d interval=%0d want 2 10", nres, second - first);
      end
      tick();
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      logic [7:0] d;
      logic br;
      int lat;
      run_op(8'h80, 8'h01, d, br, lat);
      n_tests++;
      if (d !== 8'h7F || last_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_80_01: diff=%h ovf=%b want 7F 1", d, last_ovf);
      end
      run_op(8'h05, 8'h03, d, br, lat);
      n_tests++;
      if (d !== 8'h02 || last_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_05_03: diff=%h ovf=%b want 02 0", d, last_ovf);
      end
   endtask
`endif

   initial begin
      last_ovf = 1'b0;
      test_reset();
      test_basic();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      test_input_change();
      test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
